// File: rtl/glyph_pixel_pipeline.sv
// Purpose : 8x8 font renderer for the VGA text path. Per pixel it applies glyph lookup, scaling,
//           colour, inverse, underline, blink and cursor overlay.
// Latency : 2 cycles. An input presented in cycle k appears on the outputs in cycle k+2.
//           The design has a stage-1 capture register and a stage-2 output register.
// Backpr. : none. The pipeline accepts one pixel per cycle and never stalls.
//
// Ports
//   clk, rst_n          clock (rising edge); asynchronous active-low reset, synchronous release
//   in_valid            pixel slot request this cycle
//   char_code           cell character code (lowercase letters render as uppercase)
//   h_pos, v_pos        pixel column/row inside the (8*SCALE)-wide cell
//   fg, bg              foreground / background colour
//   attr_inverse        invert the final glyph bit
//   attr_blink          blank the glyph while blink_phase is 1
//   attr_underline      force font row 7 on
//   cursor_hit          pixel is in the cursor cell; inverts while blink_phase is 0
//   frame_tick          one pulse per video frame, drives the blink timer
//   out_valid           out_on / out_color carry a pixel result
//   out_on              final glyph bit
//   out_color           fg when out_on, else bg
//   blink_phase         current blink phase
module glyph_pixel_pipeline #(
  parameter int SCALE        = 1,
  parameter int COLOR_W      = 3,
  parameter int BLINK_FRAMES = 30,
  localparam int POS_W       = 3 + $clog2(SCALE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         char_code,
  input  logic [POS_W-1:0]   h_pos,
  input  logic [POS_W-1:0]   v_pos,
  input  logic [COLOR_W-1:0] fg,
  input  logic [COLOR_W-1:0] bg,
  input  logic               attr_inverse,
  input  logic               attr_blink,
  input  logic               attr_underline,
  input  logic               cursor_hit,
  input  logic               frame_tick,
  output logic               out_valid,
  output logic               out_on,
  output logic [COLOR_W-1:0] out_color,
  output logic               blink_phase
);

  localparam int SCALE_LG = $clog2(SCALE);
  localparam int CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  // The font uses a 5x5 design in columns 1..5 and rows 1..5. The returned word holds row 0 in
  // bits [63:56]. Lowercase letters fold onto uppercase. Undefined codes render as a solid block,
  // so bad data is visible on screen.
  function automatic logic [63:0] font_glyph(input logic [7:0] code);
    logic [7:0]  c;
    logic [39:0] r;
    logic        known;
    c = code;
    if (code >= 8'd97 && code <= 8'd122) c = code - 8'd32;
    r     = 40'h0;
    known = 1'b1;
    case (c)
      8'd32:   r = 40'h00_00_00_00_00;
      8'd48:   r = 40'h38_4C_54_64_38;
      8'd49:   r = 40'h10_30_10_10_38;
      8'd50:   r = 40'h78_04_38_40_7C;
      8'd51:   r = 40'h78_04_38_04_78;
      8'd52:   r = 40'h48_48_7C_08_08;
      8'd53:   r = 40'h7C_40_78_04_78;
      8'd54:   r = 40'h38_40_78_44_38;
      8'd55:   r = 40'h7C_04_08_10_10;
      8'd56:   r = 40'h38_44_38_44_38;
      8'd57:   r = 40'h38_44_3C_04_38;
      8'd65:   r = 40'h38_44_7C_44_44;
      8'd66:   r = 40'h78_44_78_44_78;
      8'd67:   r = 40'h3C_40_40_40_3C;
      8'd68:   r = 40'h78_44_44_44_78;
      8'd69:   r = 40'h7C_40_78_40_7C;
      8'd70:   r = 40'h7C_40_78_40_40;
      8'd71:   r = 40'h3C_40_4C_44_3C;
      8'd72:   r = 40'h44_44_7C_44_44;
      8'd73:   r = 40'h38_10_10_10_38;
      8'd74:   r = 40'h1C_08_08_48_30;
      8'd75:   r = 40'h44_48_70_48_44;
      8'd76:   r = 40'h40_40_40_40_7C;
      8'd77:   r = 40'h44_6C_54_44_44;
      8'd78:   r = 40'h44_64_54_4C_44;
      8'd79:   r = 40'h38_44_44_44_38;
      8'd80:   r = 40'h78_44_78_40_40;
      8'd81:   r = 40'h38_44_54_48_34;
      8'd82:   r = 40'h78_44_78_48_44;
      8'd83:   r = 40'h3C_40_38_04_78;
      8'd84:   r = 40'h7C_10_10_10_10;
      8'd85:   r = 40'h44_44_44_44_38;
      8'd86:   r = 40'h44_44_44_28_10;
      8'd87:   r = 40'h44_44_54_6C_44;
      8'd88:   r = 40'h44_28_10_28_44;
      8'd89:   r = 40'h44_28_10_10_10;
      8'd90:   r = 40'h7C_08_10_20_7C;
      default: known = 1'b0;
    endcase
    return known ? {8'h00, r, 16'h0000} : {64{1'b1}};
  endfunction

  // Stage 1: capture the request and scale the position down to font coordinates.
  logic               r_s1_vld;
  logic [7:0]         r_s1_char;
  logic [2:0]         r_s1_col;
  logic [2:0]         r_s1_row;
  logic [COLOR_W-1:0] r_s1_fg;
  logic [COLOR_W-1:0] r_s1_bg;
  logic               r_s1_inv;
  logic               r_s1_blink;
  logic               r_s1_ul;
  logic               r_s1_cur;
  logic               r_s1_phase;

  // Blink timer state.
  logic [CNT_W-1:0]   r_blink_cnt;
  logic               r_blink_phase;

  // Stage 2: output registers.
  logic               r_out_vld;
  logic               r_out_on;
  logic [COLOR_W-1:0] r_out_color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_char  <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
      r_s1_fg    <= '0;
      r_s1_bg    <= '0;
      r_s1_inv   <= 1'b0;
      r_s1_blink <= 1'b0;
      r_s1_ul    <= 1'b0;
      r_s1_cur   <= 1'b0;
      r_s1_phase <= 1'b0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_char  <= char_code;
        r_s1_col   <= 3'(h_pos >> SCALE_LG);
        r_s1_row   <= 3'(v_pos >> SCALE_LG);
        r_s1_fg    <= fg;
        r_s1_bg    <= bg;
        r_s1_inv   <= attr_inverse;
        r_s1_blink <= attr_blink;
        r_s1_ul    <= attr_underline;
        r_s1_cur   <= cursor_hit;
        // A pixel sees the phase from before this edge, so a tick in the same
        // cycle only affects later pixels.
        r_s1_phase <= r_blink_phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == CNT_MAX) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Stage 2 combinational path: font row fetch, then bit select, then attributes.
  logic [63:0] w_glyph;
  logic [7:0]  w_rowbits;
  logic        w_font_bit;
  logic        w_g;

  assign w_glyph    = font_glyph(r_s1_char);
  // For a 3-bit value, ~x equals 7-x. Row 0 is the top byte and column 0 is the MSB.
  assign w_rowbits  = w_glyph[{~r_s1_row, 3'b000} +: 8];
  assign w_font_bit = w_rowbits[~r_s1_col];

  always_comb begin
    w_g = w_font_bit;
    if (r_s1_ul && (r_s1_row == 3'd7)) w_g = 1'b1;
    if (r_s1_blink && r_s1_phase)      w_g = 1'b0;
    if (r_s1_cur && !r_s1_phase)       w_g = ~w_g;
    if (r_s1_inv)                      w_g = ~w_g;
  end

  // During gaps, out_on and out_color keep the last pixel's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_on    <= 1'b0;
      r_out_color <= '0;
    end else begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_on    <= w_g;
        r_out_color <= w_g ? r_s1_fg : r_s1_bg;
      end
    end
  end

  assign out_valid   = r_out_vld;
  assign out_on      = r_out_on;
  assign out_color   = r_out_color;
  assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_glyph_pixel_pipeline.sv
// Purpose : directed bench for glyph_pixel_pipeline.
//           Two instances are used: one with SCALE=1 and one with SCALE=2, both with BLINK_FRAMES=2.
// Latency : outputs are sampled 1 time unit after the second rising edge that follows the drive.
// Backpr. : not applicable; the stimulus streams freely.
module tb_glyph_pixel_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [7:0] char_code;
  logic [2:0] h1, v1;
  logic [3:0] h2, v2;
  logic [2:0] fg, bg;
  logic       attr_inverse, attr_blink, attr_underline, cursor_hit, frame_tick;

  logic       o1_vld, o1_on, o1_ph;
  logic [2:0] o1_col;
  logic       o2_vld, o2_on, o2_ph;
  logic [2:0] o2_col;

  glyph_pixel_pipeline #(.SCALE(1), .COLOR_W(3), .BLINK_FRAMES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char_code(char_code),
    .h_pos(h1), .v_pos(v1), .fg(fg), .bg(bg),
    .attr_inverse(attr_inverse), .attr_blink(attr_blink), .attr_underline(attr_underline),
    .cursor_hit(cursor_hit), .frame_tick(frame_tick),
    .out_valid(o1_vld), .out_on(o1_on), .out_color(o1_col), .blink_phase(o1_ph)
  );

  glyph_pixel_pipeline #(.SCALE(2), .COLOR_W(3), .BLINK_FRAMES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char_code(char_code),
    .h_pos(h2), .v_pos(v2), .fg(fg), .bg(bg),
    .attr_inverse(attr_inverse), .attr_blink(attr_blink), .attr_underline(attr_underline),
    .cursor_hit(cursor_hit), .frame_tick(frame_tick),
    .out_valid(o2_vld), .out_on(o2_on), .out_color(o2_col), .blink_phase(o2_ph)
  );

  typedef struct {
    logic [7:0] ch;
    logic [2:0] h, v, f, b;
    logic       inv, blk, ul, cur;
    logic       e_on;
    logic [2:0] e_col;
  } vec_t;

  vec_t       tbl[20];
  logic [7:0] a_rows[8];
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    in_valid       = 1'b1;
    char_code      = t.ch;
    h1             = t.h;
    v1             = t.v;
    fg             = t.f;
    bg             = t.b;
    attr_inverse   = t.inv;
    attr_blink     = t.blk;
    attr_underline = t.ul;
    cursor_hit     = t.cur;
  endtask

  task automatic apply(input string nm, input vec_t t);
    drive(t);
    step();
    in_valid = 1'b0;
    step();
    chk({nm, "_vld"}, o1_vld, 1);
    chk({nm, "_on"}, o1_on, t.e_on);
    chk({nm, "_col"}, o1_col, t.e_col);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Streams 64 pixels back to back and checks each result two cycles after it is driven.
  // Positions: sel2=0 covers the whole 8x8 cell of u_dut1; sel2=1 covers v=2..5, h=0..15 of u_dut2.
  task automatic stream(input bit sel2, input logic [7:0] ch);
    int   p, h, v, r, c;
    logic [7:0] bits;
    logic e;
    fg = 3'd7; bg = 3'd1;
    attr_inverse = 0; attr_blink = 0; attr_underline = 0; cursor_hit = 0;
    for (int i = 0; i <= 65; i++) begin
      if (i >= 2) begin
        p = i - 2;
        if (sel2) begin h = p % 16; v = 2 + p / 16; r = v / 2; c = h / 2; end
        else      begin h = p % 8;  v = p / 8;      r = v;     c = h;     end
        bits = a_rows[r];
        e    = bits[7 - c];
        if (sel2) begin
          chk($sformatf("s2_vld_h%0d_v%0d", h, v), o2_vld, 1);
          chk($sformatf("s2_on_h%0d_v%0d", h, v), o2_on, e);
        end else begin
          chk($sformatf("ch%0d_vld_h%0d_v%0d", ch, h, v), o1_vld, 1);
          chk($sformatf("ch%0d_on_h%0d_v%0d", ch, h, v), o1_on, e);
          chk($sformatf("ch%0d_col_h%0d_v%0d", ch, h, v), o1_col, e ? 7 : 1);
        end
      end
      if (i < 64) begin
        in_valid  = 1'b1;
        char_code = ch;
        if (sel2) begin h2 = 4'(i % 16); v2 = 4'(2 + i / 16); end
        else      begin h1 = 3'(i % 8);  v1 = 3'(i / 8);      end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
  endtask

  vec_t t;

  initial begin
    a_rows[0] = 8'h00; a_rows[1] = 8'h38; a_rows[2] = 8'h44; a_rows[3] = 8'h7C;
    a_rows[4] = 8'h44; a_rows[5] = 8'h44; a_rows[6] = 8'h00; a_rows[7] = 8'h00;

    //            ch     h    v    fg   bg   inv  blk  ul   cur  on   col
    tbl[0]  = '{8'd65, 3'd2, 3'd1, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    tbl[1]  = '{8'd65, 3'd1, 3'd1, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[2]  = '{8'd200,3'd0, 3'd0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5};
    tbl[3]  = '{8'd200,3'd7, 3'd7, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5};
    tbl[4]  = '{8'd0,  3'd4, 3'd3, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[5]  = '{8'd32, 3'd3, 3'd7, 3'd6, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6};
    tbl[6]  = '{8'd32, 3'd3, 3'd7, 3'd6, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[7]  = '{8'd32, 3'd4, 3'd4, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6};
    tbl[8]  = '{8'd32, 3'd4, 3'd4, 3'd6, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3};
    tbl[9]  = '{8'd65, 3'd2, 3'd1, 3'd7, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[10] = '{8'd65, 3'd2, 3'd1, 3'd7, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7};
    tbl[11] = '{8'd65, 3'd0, 3'd7, 3'd7, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7};
    tbl[12] = '{8'd48, 3'd3, 3'd0, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[13] = '{8'd90, 3'd3, 3'd6, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[14] = '{8'd97, 3'd1, 3'd2, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    tbl[15] = '{8'd65, 3'd5, 3'd3, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    tbl[16] = '{8'd65, 3'd3, 3'd2, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[17] = '{8'd65, 3'd2, 3'd1, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
    tbl[18] = '{8'd127,3'd6, 3'd6, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
    tbl[19] = '{8'd32, 3'd0, 3'd7, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3};

    rst_n = 1'b0; in_valid = 1'b0; char_code = '0; h1 = '0; v1 = '0; h2 = '0; v2 = '0;
    fg = '0; bg = '0; attr_inverse = 0; attr_blink = 0; attr_underline = 0;
    cursor_hit = 0; frame_tick = 0;
    step(); step();
    chk("rst_vld", o1_vld, 0);
    chk("rst_on", o1_on, 0);
    chk("rst_col", o1_col, 0);
    chk("rst_phase", o1_ph, 0);
    chk("rst_vld2", o2_vld, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Gap: out_valid drops, but the last result stays on out_on/out_color.
    apply("gap_pre", tbl[0]);
    step();
    chk("gap_vld", o1_vld, 0);
    chk("gap_on_hold", o1_on, 1);
    chk("gap_col_hold", o1_col, 7);

    stream(1'b0, 8'd65);
    stream(1'b0, 8'd97);
    stream(1'b1, 8'd65);

    // Blink timer with BLINK_FRAMES=2.
    tick();
    chk("blink_after_1", o1_ph, 0);
    tick();
    chk("blink_after_2", o1_ph, 1);
    chk("blink2_after_2", o2_ph, 1);
    t = tbl[10]; t.e_on = 1'b0; t.e_col = 3'd1;
    apply("blink_ph1", t);
    t = tbl[17]; t.e_on = 1'b1; t.e_col = 3'd7;
    apply("cursor_ph1", t);
    t = tbl[7];  t.e_on = 1'b0; t.e_col = 3'd3;
    apply("cursor_space_ph1", t);
    t = tbl[19]; t.blk = 1'b1; t.inv = 1'b1; t.e_on = 1'b1; t.e_col = 3'd6;
    apply("blink_inv_ph1", t);
    tick();
    chk("blink_after_3", o1_ph, 1);
    // The tick toggles the phase on the edge that captures this pixel, so the pixel still uses phase 1.
    t = tbl[10];
    drive(t);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    in_valid   = 1'b0;
    chk("blink_after_4", o1_ph, 0);
    step();
    chk("sametick_vld", o1_vld, 1);
    chk("sametick_on", o1_on, 0);
    t = tbl[10];
    apply("blink_ph0_again", t);

    // Reset with pixels in flight: outputs clear at once, and nothing is emitted after release.
    tick(); tick();
    chk("pre_rst_phase", o1_ph, 1);
    drive(tbl[0]);
    step();
    step();
    chk("pre_rst_vld", o1_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", o1_vld, 0);
    chk("async_rst_on", o1_on, 0);
    chk("async_rst_col", o1_col, 0);
    chk("async_rst_phase", o1_ph, 0);
    chk("async_rst_vld2", o2_vld, 0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_vld%0d", i), o1_vld, 0);
      chk($sformatf("post_rst2_vld%0d", i), o2_vld, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
